// File: rtl/sdram_host_emu_pkg.sv
// sdram_host_emu_pkg: shared state/request types, default latencies and data width
// for the on-chip SDRAM controller emulator.
package sdram_host_emu_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ, REFRESH} state_t;
    typedef enum logic {RD, WR} req_t;

    localparam int DW = 16;
    localparam int DEF_RD_LAT = 8;
    localparam int DEF_WR_LAT = 6;
    localparam int DEF_REF_PERIOD = 780;
    localparam int DEF_REF_CYCLES = 7;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/sdram_host_emu_ref_timer.sv
// sdram_host_emu_ref_timer: free-running refresh interval counter with a single
// outstanding-refresh flag that is cleared when the refresh is taken.
module sdram_host_emu_ref_timer #(
    parameter int REF_PERIOD = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ref_ack,
    output logic o_ref_due
);

    localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(REF_PERIOD - 1));

    // Wraps while a refresh is still owed simply re-assert the flag; they never stack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            o_ref_due <= 1'b0;
        end else begin
            r_cnt     <= w_wrap ? '0 : r_cnt + 1'b1;
            o_ref_due <= w_wrap | (o_ref_due & ~i_ref_ack);
        end
    end

endmodule

// File: rtl/sdram_host_emu.sv
// sdram_host_emu: SDRAM-controller-timed host responder backed by an on-chip RAM.
// Optional SDRAM_HOST_EMU_STATS_EN adds drop_cnt/ref_cnt statistics outputs.
module sdram_host_emu
    import sdram_host_emu_pkg::*;
#(
    parameter int HADDR_WIDTH = 24,
    parameter int MEM_AW      = 8,
    parameter int RD_LAT      = DEF_RD_LAT,
    parameter int WR_LAT      = DEF_WR_LAT,
    parameter int REF_PERIOD  = DEF_REF_PERIOD,
    parameter int REF_CYCLES  = DEF_REF_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [HADDR_WIDTH-1:0] haddr,
    input  logic [DW-1:0]          data_input,
    input  logic                   rd_enable,
    input  logic                   wr_enable,
`ifdef SDRAM_HOST_EMU_STATS_EN
    output logic [15:0]            drop_cnt,
    output logic [15:0]            ref_cnt,
`endif
    output logic [DW-1:0]          data_output,
    output logic                   busy
);

    localparam int LW = $clog2(max3(RD_LAT, WR_LAT, REF_CYCLES) + 1);
    localparam logic [LW-1:0] C_RD = LW'(RD_LAT - 1);
    localparam logic [LW-1:0] C_WR = LW'(WR_LAT - 1);
    localparam logic [LW-1:0] C_RF = LW'(REF_CYCLES - 1);

    state_t              r_state;
    req_t                r_type;
    logic [LW-1:0]       r_cnt;
    logic [MEM_AW-1:0]   r_addr;
    logic [DW-1:0]       r_wdata;
    logic                r_pend;
    logic [DW-1:0]       r_mem [0:2**MEM_AW-1];
    logic                w_req;
    logic                w_last;
    logic                w_ref_due;
    logic                w_ref_ack;
    logic                w_unused_hi;

    assign w_req       = rd_enable | wr_enable;
    assign w_last      = (r_cnt == '0);
    assign w_ref_ack   = (r_state == IDLE) & w_ref_due;
    assign w_unused_hi = ^haddr[HADDR_WIDTH-1:MEM_AW];

    sdram_host_emu_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
        .clk       (clk),
        .rst       (rst),
        .i_ref_ack (w_ref_ack),
        .o_ref_due (w_ref_due)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            busy        <= 1'b0;
            data_output <= '0;
            r_pend      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr  <= haddr[MEM_AW-1:0];
                        r_wdata <= data_input;
                        r_type  <= wr_enable ? WR : RD;
                    end
                    // A due refresh beats a same-cycle request, which waits in the pending slot.
                    if (w_ref_due) begin
                        r_state <= REFRESH;
                        busy    <= 1'b1;
                        r_cnt   <= C_RF;
                        r_pend  <= w_req;
                    end else if (w_req) begin
                        r_state <= wr_enable ? WRITE : READ;
                        busy    <= 1'b1;
                        r_cnt   <= wr_enable ? C_WR : C_RD;
                    end
                end
                REFRESH: begin
                    r_cnt <= w_last ? ((r_type == WR) ? C_WR : C_RD) : r_cnt - 1'b1;
                    if (w_last) begin
                        r_state <= !r_pend ? IDLE : ((r_type == WR) ? WRITE : READ);
                        busy    <= r_pend;
                        r_pend  <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        if (r_state == READ) data_output <= r_mem[r_addr];
                    end
                end
            endcase
        end
    end

    // The array has no reset; a reset on the final write edge cancels the update.
    always_ff @(posedge clk) begin
        if (!rst && r_state == WRITE && w_last) r_mem[r_addr] <= r_wdata;
    end

`ifdef SDRAM_HOST_EMU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            ref_cnt  <= '0;
        end else begin
            if (w_req && r_state != IDLE && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
            if (w_ref_ack) ref_cnt <= ref_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/sdram_host_emu.md
Name: sdram_host_emu

Overview:
- Responder side of the SDRAM controller host interface: accepts haddr/data_input with rd_enable/wr_enable pulses and returns busy/data_output.
- Timing matches the real controller, backed by a small on-chip RAM.
- Drop-in substitute for the SDRAM controller, so the board button/DIP front end can be brought up without external SDRAM.
- Periodic refresh windows are emulated, so initiators see realistic busy stalls.

Parameters:
- HADDR_WIDTH, 24: host address width.
- MEM_AW, 8: RAM address bits; depth is 2**MEM_AW 16-bit words.
- RD_LAT, 8: busy cycles per read, at least 2.
- WR_LAT, 6: busy cycles per write, at least 2.
- REF_PERIOD, 780: cycles between refresh requests.
- REF_CYCLES, 7: busy cycles per refresh, at least 1.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: reset; synchronous and active-high.
- haddr, input, HADDR_WIDTH: request address.
- data_input, input, 16: write data.
- rd_enable, input, 1: read request pulse.
- wr_enable, input, 1: write request pulse.
- data_output, output, 16: read data, held until the next read completes.
- busy, output, 1: high while a request or refresh is being serviced.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - busy = 0, data_output = 0, state = IDLE.
  - Pending slot empty; refresh counter = 0.
  - RAM contents are not reset.
- Address mapping: RAM index = haddr[MEM_AW-1:0]; upper bits are ignored, so addresses alias.
- States: IDLE, WRITE, READ, REFRESH.
- Request accept: a request is accepted at edge T when state = IDLE, busy = 0 and rd_enable or wr_enable is high.
  - The request's address, data and type are captured at T.
  - If both enables are high, write wins; the read is discarded.
- WRITE timing:
  - busy = 1 from the cycle after T for WR_LAT cycles.
  - The RAM is written at the edge ending the last busy cycle.
  - busy = 0 from the cycle after that.
- READ timing:
  - busy = 1 for RD_LAT cycles.
  - data_output is loaded at the same edge busy falls, so it is valid in the first cycle busy = 0.
  - data_output is held until the next read completes; writes and refreshes never change it.
- Refresh counter:
  - Free-running 0..REF_PERIOD-1; wraps to 0.
  - Sets ref_due at the wrap.
  - ref_due clears when REFRESH is entered.
- Refresh priority:
  - In IDLE with ref_due = 1: enter REFRESH; busy = 1 for REF_CYCLES; then return to IDLE.
  - If a request arrives in the same cycle REFRESH is entered, it is captured in a one-deep pending slot.
  - The pending request is then serviced directly after REFRESH (REFRESH to WRITE/READ) with no idle gap; busy stays high throughout.
- Requests ignored: rd_enable/wr_enable while busy = 1, or while the pending slot is full, are ignored with no side effect.
- A refresh that becomes due during READ/WRITE waits for IDLE. Counter wraps meanwhile do not stack: at most one refresh is outstanding.
- Reset mid-operation:
  - The transaction is aborted; busy = 0 next cycle.
  - An aborted write does not update the RAM.
  - An aborted read leaves data_output = 0 (reset value).
- Counters: latency counter is width-sized with $clog2(max(RD_LAT, WR_LAT, REF_CYCLES)+1). Refresh counter is $clog2(REF_PERIOD) bits.

Optional Feature:
- Macro SDRAM_HOST_EMU_STATS_EN.
- Defined:
  - Adds output drop_cnt [15:0]: counts cycles where rd_enable or wr_enable was ignored. It is incremented at most once per cycle, saturates at 0xFFFF, and is reset to 0.
  - Adds output ref_cnt [15:0]: counts REFRESH entries; it wraps and is reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package sdram_host_emu_pkg holds:
  - The state enum: IDLE, WRITE, READ, REFRESH.
  - The request-type encoding: RD, WR.
  - Default latency constants.
  - The 16-bit data width constant.
- Sub-module sdram_host_emu_ref_timer:
  - Contains the refresh counter plus the ref_due flag, with ref_ack input.
  - Parameter: REF_PERIOD.
- The RAM is an inferred array in the top module; it is not a separate module.

Test Plan:
- Write/read-back: pulse wr_enable with haddr=0x000012, data_input=0x5AA5; wait for busy to fall; pulse rd_enable at the same address. Required: busy high exactly 6 then 8 cycles; data_output=0x5AA5 in the first cycle busy=0.
- Aliasing with MEM_AW=8:
  - Write 0x1234 to 0x000105, then read 0x000005. Required: data_output=0x1234.
  - Then write 0xBEEF to 0x000005. Required: data_output stays 0x1234.
- Simultaneous rd+wr in IDLE at address 0x20 with data 0xCAFE. Required: a write is performed (busy for 6 cycles); a later read returns 0xCAFE; data_output is unchanged by the collision itself.
- Refresh collision (REF_PERIOD=32, REF_CYCLES=7): issue rd_enable in the exact cycle ref_due causes REFRESH entry. Required: busy high continuously for 7+8=15 cycles; correct read data when busy falls.
- Busy-ignore: rd_enable pulses on cycles 2 and 4 of a write. Required: exactly one transaction occurs; with STATS_EN, drop_cnt=2.
- Reset mid-read: assert rst on the 3rd busy cycle of a read of a location holding 0x7777. Required: busy=0 and data_output=0 the next cycle; a subsequent read returns 0x7777.
